// File: rtl/iob_mem_arb_pkg.sv
// Shared definitions for the tiled two-port memory arbiter: FSM encoding and
// the index-width helper used to size the round-robin pointer.
package iob_mem_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // Bits needed to index n items; callers guarantee n >= 2 so the result is >= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/iob_rr_arb.sv
// Combinational round-robin arbiter: grants the first valid requester found
// when scanning upward from the priority pointer, wrapping modulo N_REQ.
module iob_rr_arb
  import iob_mem_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]        valid_i,
  input  logic [clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]        grant_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_2p_mem_tiled_arb.sv
// Arbitrates N_REQ requesters onto one single-port tiled memory; optionally
// zero-fills the memory after reset before accepting any request.
module iob_2p_mem_tiled_arb
  import iob_mem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 13,
  parameter int N_REQ      = 2,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // ready is never raised without valid, and responses cannot be back-pressured.
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_w_en,
  output logic                     mem_r_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [DATA_W-1:0]        mem_data_out,
  output arb_state_e               dbg_state_o
);

  localparam int                IDX_W     = clog2(N_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  rsp_q, rsp_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  logic [N_REQ-1:0]  arb_valid;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  gidx;
  logic              any_grant;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              w_en_c, r_en_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;

  assign arb_valid = (state_q == ST_RUN) ? req_valid : '0;

  iob_rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
    .valid_i (arb_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gidx = IDX_W'(i);
    end
  end

  assign any_grant = |grant;
  assign g_we      = req_we[gidx];
  assign g_addr    = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign g_wdata   = req_wdata[int'(gidx)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ptr_d       = ptr_q;
    rsp_d       = '0;
    w_en_c      = 1'b0;
    r_en_c      = 1'b0;
    addr_c      = hold_addr_q;
    data_c      = hold_data_q;
    case (state_q)
      ST_INIT: begin
        w_en_c = 1'b1;
        addr_c = init_cnt_q;
        data_c = '0;
        // The counter parks on the last address instead of wrapping.
        if (init_cnt_q == LAST_ADDR) state_d = ST_RUN;
        else                         init_cnt_d = init_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (any_grant) begin
          ptr_d  = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
          addr_c = g_addr;
          if (g_we) begin
            w_en_c = 1'b1;
            data_c = g_wdata;
          end else begin
            r_en_c      = 1'b1;
            rsp_d[gidx] = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    hold_addr_d = addr_c;
    hold_data_d = data_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      ptr_q       <= '0;
      rsp_q       <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ptr_q       <= ptr_d;
      rsp_q       <= rsp_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Outputs are forced quiet while rst is high, which also drops a response
  // whose read was granted in the cycle just before reset.
  assign req_ready   = rst ? '0 : grant;
  assign rsp_valid   = rst ? '0 : rsp_q;
  assign rsp_rdata   = (|rsp_valid) ? mem_data_out : '0;
  assign mem_w_en    = ~rst & w_en_c;
  assign mem_r_en    = ~rst & r_en_c;
  assign mem_addr    = rst ? '0 : addr_c;
  assign mem_data_in = rst ? '0 : data_c;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_2p_mem_tiled_arb.sv
// Directed bench for the tiled memory arbiter with a behavioural memory,
// a read-response scoreboard and always-on mutual-exclusion checks.
module tb_iob_2p_mem_tiled_arb;
  import iob_mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           mem_w_en, mem_r_en;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_data_in;
  logic [DW-1:0]  mem_data_out;
  arb_state_e     dbg_state;

  iob_2p_mem_tiled_arb #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(NR), .INIT_CLEAR(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_w_en     (mem_w_en),
    .mem_r_en     (mem_r_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .dbg_state_o  (dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_data_in;
    if (mem_r_en) mem_data_out <= mem[mem_addr];
  end

  // scoreboard state
  int              vectors = 0;
  int              miscompares = 0;
  logic [DW-1:0]   exp_q[$];
  logic [NR-1:0]   own_q[$];
  logic [DW-1:0]   ref_mem [16];
  logic [AW-1:0]   last_addr;
  logic [DW-1:0]   last_data;
  logic [NR-1:0]   pend_rsp;
  logic            ptr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rw_mutex", DW'(mem_w_en & mem_r_en), 0);
    chk("ready_onehot", DW'($countones(req_ready) <= 1), 1);
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    last_addr = 4'hF;
    last_data = '0;
    pend_rsp  = '0;
    ptr       = 1'b0;
  endtask

  // Checks the 16-cycle zero-fill; entered in the first cycle after rst falls.
  task automatic init_sweep();
    for (int i = 0; i < 16; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("init_state", DW'(dbg_state), DW'(ST_INIT));
      chk("init_w_en", DW'(mem_w_en), 1);
      chk("init_r_en", DW'(mem_r_en), 0);
      chk("init_addr", DW'(mem_addr), DW'(i));
      chk("init_data", mem_data_in, 0);
      chk("init_ready", DW'(req_ready), 0);
      chk("init_rsp", DW'(rsp_valid), 0);
    end
    model_clear();
  endtask

  // One RUN cycle: drive, then check grant, memory port and any response.
  task automatic cyc(input logic [1:0] v, input logic [1:0] we,
                     input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic [1:0] exp_rdy);
    logic          g;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic [DW-1:0] e;
    logic [NR-1:0] o;
    @(posedge clk); #1;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(negedge clk);
    chk("run_state", DW'(dbg_state), DW'(ST_RUN));
    chk("ready", DW'(req_ready), DW'(exp_rdy));
    chk("rsp_valid", DW'(rsp_valid), DW'(pend_rsp));
    if (rsp_valid !== '0) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", DW'(rsp_valid), 0);
      else begin
        e = exp_q.pop_front();
        o = own_q.pop_front();
        chk("rsp_owner", DW'(rsp_valid), DW'(o));
        chk("rsp_rdata", rsp_rdata, e);
      end
    end
    pend_rsp = '0;
    if (exp_rdy == 2'b00) begin
      chk("idle_w_en", DW'(mem_w_en), 0);
      chk("idle_r_en", DW'(mem_r_en), 0);
      chk("idle_addr_hold", DW'(mem_addr), DW'(last_addr));
      chk("idle_data_hold", mem_data_in, last_data);
    end else begin
      g  = exp_rdy[1];
      ga = g ? a1 : a0;
      gd = g ? d1 : d0;
      chk("gnt_addr", DW'(mem_addr), DW'(ga));
      if (we[g]) begin
        chk("wr_w_en", DW'(mem_w_en), 1);
        chk("wr_r_en", DW'(mem_r_en), 0);
        chk("wr_data", mem_data_in, gd);
        ref_mem[ga] = gd;
        last_data   = gd;
      end else begin
        chk("rd_r_en", DW'(mem_r_en), 1);
        chk("rd_w_en", DW'(mem_w_en), 0);
        exp_q.push_back(ref_mem[ga]);
        own_q.push_back(exp_rdy);
        pend_rsp = exp_rdy;
      end
      last_addr = ga;
      ptr       = ~g;
    end
  endtask

  logic [1:0]    rv, rw, rr;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_addr  = '0;
    req_wdata = '0;
    // reset state: everything quiet even with requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", DW'(req_ready), 0);
      chk("rst_rsp", DW'(rsp_valid), 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_w_en", DW'(mem_w_en), 0);
      chk("rst_r_en", DW'(mem_r_en), 0);
      chk("rst_addr", DW'(mem_addr), 0);
      chk("rst_data", mem_data_in, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    init_sweep();

    // both requesters writing: grants alternate starting at requester 0
    cyc(2'b11, 2'b11, 4'd1, 32'h1111_0001, 4'd2, 32'h2222_0002, 2'b01);
    cyc(2'b11, 2'b11, 4'd3, 32'h1111_0003, 4'd2, 32'h2222_0002, 2'b10);
    cyc(2'b11, 2'b11, 4'd3, 32'h1111_0003, 4'd4, 32'h2222_0004, 2'b01);
    cyc(2'b11, 2'b11, 4'd6, 32'h1111_0006, 4'd4, 32'h2222_0004, 2'b10);
    // write then immediate read of the same address
    cyc(2'b01, 2'b01, 4'd5, 32'hDEAD_BEEF, 4'd0, 32'h0, 2'b01);
    cyc(2'b01, 2'b00, 4'd5, 32'h0, 4'd0, 32'h0, 2'b01);
    cyc(2'b00, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 2'b00);
    // lone requester 1: back-to-back reads, back-to-back responses
    cyc(2'b10, 2'b00, 4'd0, 32'h0, 4'd1, 32'h0, 2'b10);
    cyc(2'b10, 2'b00, 4'd0, 32'h0, 4'd2, 32'h0, 2'b10);
    cyc(2'b10, 2'b00, 4'd0, 32'h0, 4'd3, 32'h0, 2'b10);
    cyc(2'b00, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 2'b00);

    // random traffic against the round-robin expectation
    for (int n = 0; n < 40; n++) begin
      rv  = 2'($urandom_range(0, 3));
      rw  = 2'($urandom_range(0, 3));
      ra0 = 4'($urandom_range(0, 15));
      ra1 = 4'($urandom_range(0, 15));
      rd0 = $urandom;
      rd1 = $urandom;
      if (rv == 2'b00)  rr = 2'b00;
      else if (rv[ptr]) rr = ptr ? 2'b10 : 2'b01;
      else              rr = ptr ? 2'b01 : 2'b10;
      cyc(rv, rw, ra0, rd0, ra1, rd1, rr);
    end
    cyc(2'b00, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 2'b00);

    // one-cycle reset right after a read grant: response dropped, sweep restarts
    cyc(2'b01, 2'b00, 4'd2, 32'h0, 4'd0, 32'h0, 2'b01);
    void'(exp_q.pop_back());
    void'(own_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rstmid_rsp", DW'(rsp_valid), 0);
    chk("rstmid_r_en", DW'(mem_r_en), 0);
    chk("rstmid_addr", DW'(mem_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_sweep();

    // memory was cleared by the new sweep; first read after it starts at ptr 0
    cyc(2'b11, 2'b00, 4'd5, 32'h0, 4'd4, 32'h0, 2'b01);
    cyc(2'b10, 2'b00, 4'd0, 32'h0, 4'd4, 32'h0, 2'b10);
    cyc(2'b00, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 2'b00);

    chk("scoreboard_drained", DW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_2p_mem_tiled_arb.md
IOB_2P_MEM_TILED_ARB -- requirements
Module: iob_2p_mem_tiled_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width of memory and requesters.
REQ-002 SHALL have parameter ADDR_W, default 13: word address width driven to the tiled memory.
REQ-003 SHALL have parameter N_REQ, default 2, legal 2..4: number of requesters.
REQ-004 SHALL have parameter INIT_CLEAR, default 1: when 1, memory is zero-filled after reset.
REQ-005 SHALL have port clk input 1: sole clock, all logic on rising edge.
REQ-006 SHALL have port rst input 1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid input N_REQ: per-requester request valid.
REQ-008 SHALL have port req_we input N_REQ: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr input N_REQ*ADDR_W: flattened addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata input N_REQ*DATA_W: flattened write data, same packing.
REQ-011 SHALL have port req_ready output N_REQ: one-hot grant; the request is accepted when valid & ready.
REQ-012 SHALL have port rsp_valid output N_REQ: one-cycle read-response pulse to the owning requester.
REQ-013 SHALL have port rsp_rdata output DATA_W: read data, shared by all requesters, qualified by rsp_valid.
REQ-014 SHALL have ports mem_w_en, mem_r_en output 1; mem_addr output ADDR_W; mem_data_in output DATA_W: drive the tiled memory.
REQ-015 SHALL have port mem_data_out input DATA_W: tiled memory read data, valid one cycle after mem_r_en.

Function
REQ-016 SHALL implement FSM states INIT and RUN.
REQ-017 INIT SHALL drive mem_w_en=1, mem_data_in=0, mem_addr=init counter, and keep req_ready=0.
REQ-018 The init counter SHALL start at 0, increment each cycle, and move to RUN on the cycle it writes 2**ADDR_W-1, with no wrap to 0.
REQ-019 With INIT_CLEAR=0, reset SHALL enter RUN directly.
REQ-020 In RUN, at most one request SHALL be granted per cycle, round-robin, starting at a priority pointer.
REQ-021 req_ready SHALL be combinational from req_valid and the pointer; no ready without a valid.
REQ-022 On a grant to requester g, the pointer SHALL become (g+1) mod N_REQ; with no grant the pointer SHALL hold.
REQ-023 A granted write SHALL assert mem_w_en with that requester's addr and wdata in the same cycle; mem_r_en=0.
REQ-024 A granted read SHALL assert mem_r_en with that requester's addr in the same cycle; mem_w_en=0.
REQ-025 mem_w_en and mem_r_en SHALL never be high together.
REQ-026 A granted read SHALL register its owner; next cycle rsp_valid[owner]=1 and rsp_rdata=mem_data_out (latency 1).
REQ-027 rsp_valid SHALL have no backpressure, and back-to-back reads SHALL give back-to-back responses.
REQ-028 A read one cycle after a write to the same address SHALL return the new data.
REQ-029 A lone requester holding valid SHALL be granted every cycle, for full throughput.
REQ-030 With no grant, mem_w_en=mem_r_en=0, and mem_addr and mem_data_in SHALL hold their previous values.

Reset
REQ-031 rst SHALL set: state=INIT (or RUN if INIT_CLEAR=0), init counter=0, pointer=0, pending-read flag=0.
REQ-032 After reset, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_w_en=0, mem_r_en=0, mem_addr=0, mem_data_in=0 until the first clock after rst falls.
REQ-033 rst during INIT SHALL restart the sweep at address 0.
REQ-034 rst during RUN SHALL drop any in-flight read response.

Structure
REQ-035 Package iob_mem_arb_pkg SHALL hold the state encoding (INIT, RUN) and the index width function clog2(N_REQ).
REQ-036 The round-robin grant logic SHALL be sub-module iob_rr_arb (inputs: valid vector and pointer; output: one-hot grant), and it SHALL be combinational.
REQ-037 Total RTL SHALL be under 400 lines.

Verification
REQ-038 Reset with INIT_CLEAR=1, ADDR_W=4 -> 16 consecutive writes of 0 to addresses 0..15, req_ready=0 throughout, then RUN.
REQ-039 Requesters 0 and 1 both request continuously -> grants alternate 0,1,0,1, with pointer 0 after reset.
REQ-040 Req0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> next cycle rsp_valid=0b01, rsp_rdata=0xDEADBEEF.
REQ-041 Req1 issues 3 back-to-back reads of addrs 1,2,3 -> rsp_valid[1] high for 3 consecutive cycles, and the data matches the prior writes.
REQ-042 rst asserted for 1 cycle, one cycle after a read grant -> no rsp_valid pulse, and the sweep restarts at 0.
REQ-043 All scenarios -> mem_w_en and mem_r_en never high together; req_ready is always one-hot or zero.
